// File: rtl/prv32_id_ex_stage_pkg.sv
// prv32_id_ex_stage_pkg: RV32I opcode constants and ALU function codes shared by the ID/EX stage.
package prv32_id_ex_stage_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    function automatic logic writes_rd(input logic [6:0] op);
        return op == OPC_OP || op == OPC_OP_IMM || op == OPC_LUI || op == OPC_AUIPC ||
               op == OPC_LOAD || op == OPC_JAL || op == OPC_JALR;
    endfunction
endpackage

// File: rtl/prv32_id_ex_stage_fwd_unit.sv
// prv32_fwd_unit: picks the freshest value for one EX source register (EX/MEM over MEM/WB over regfile).
module prv32_fwd_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_we,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   data
);
    logic exm_hit, wb_hit;

    // x0 is hardwired, so a write to it must never be forwarded
    assign exm_hit = exm_we && exm_rd == rs && exm_rd != '0;
    assign wb_hit  = wb_we && wb_rd == rs && wb_rd != '0;
    assign data    = exm_hit ? exm_result : wb_hit ? wb_result : reg_data;
endmodule

// File: rtl/prv32_id_ex_stage.sv
// prv32_id_ex_stage: ID/EX pipeline register with ALU function decode, operand forwarding
// and load-use stall detection.
module prv32_id_ex_stage
    import prv32_id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [6:0]        id_opcode,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              flush,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_we,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic              hazard_stall,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_fn,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_we,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_store_data
);
    logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data, ex_imm, fwd_rs1, fwd_rs2;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic [3:0]        ex_alufn;
    logic              ex_a_pc, ex_b_imm;

    function automatic logic [3:0] alufn_dec(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        logic [3:0] r;
        if (op == OPC_OP || op == OPC_OP_IMM) begin
            case (f3)
                3'b000:  r = (op == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  r = ALU_SLL;
                3'b010:  r = ALU_SLT;
                3'b011:  r = ALU_SLTU;
                3'b100:  r = ALU_XOR;
                3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  r = ALU_OR;
                default: r = ALU_AND;
            endcase
        end else begin
            r = op == OPC_LUI ? ALU_PASS : op == OPC_BRANCH ? ALU_SUB : ALU_ADD;
        end
        return r;
    endfunction

    // the bubble that follows clears ex_is_load, so the stall lasts one cycle per pair
    assign hazard_stall = id_valid && ex_valid && ex_is_load && ex_rd != '0 &&
                          (ex_rd == id_rs1 || ex_rd == id_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_we       <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_pc       <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_alufn    <= ALU_ADD;
            ex_a_pc     <= 1'b0;
            ex_b_imm    <= 1'b0;
        end else if (flush || hazard_stall) begin
            ex_valid    <= 1'b0;
            ex_we       <= 1'b0;
            ex_is_load  <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_we       <= id_valid && writes_rd(id_opcode);
            ex_is_load  <= id_valid && id_opcode == OPC_LOAD;
            ex_pc       <= id_pc;
            ex_rd       <= id_rd;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_alufn    <= alufn_dec(id_opcode, id_funct3, id_funct7b5);
            ex_a_pc     <= id_opcode == OPC_AUIPC;
            ex_b_imm    <= id_opcode != OPC_OP && id_opcode != OPC_BRANCH;
        end
    end

    prv32_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs(ex_rs1), .reg_data(ex_rs1_data),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
        .data(fwd_rs1)
    );

    prv32_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs(ex_rs2), .reg_data(ex_rs2_data),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
        .data(fwd_rs2)
    );

    assign alu_a         = ex_a_pc ? ex_pc : fwd_rs1;
    assign alu_b         = ex_b_imm ? ex_imm : fwd_rs2;
    assign alu_shamt     = alu_b[4:0];
    assign alu_fn        = ex_alufn;
    assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// tb_prv32_id_ex_stage: table-driven decode/operand vectors plus directed forwarding,
// load-use, flush and reset sequences.
module tb_prv32_id_ex_stage;
    import prv32_id_ex_stage_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, id_funct7b5 = 1'b0, flush = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [6:0]  id_opcode = '0;
    logic [2:0]  id_funct3 = '0;
    logic [4:0]  exm_rd = '0, wb_rd = '0;
    logic        exm_we = 1'b0, wb_we = 1'b0;
    logic [31:0] exm_result = '0, wb_result = '0;
    logic        hazard_stall, ex_valid, ex_we, ex_is_load;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [4:0]  alu_shamt, ex_rd;
    logic [3:0]  alu_fn;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc, d1, d2, imm;
        logic [3:0]  fn;
        logic [31:0] a, b;
        logic        we;
    } vec_t;
    vec_t vecs[$];

    prv32_id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .flush(flush),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
        .hazard_stall(hazard_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_fn(alu_fn), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [31:0] pc);
        id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7b5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [3:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic we);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.pc = pc; v.d1 = d1; v.d2 = d2; v.imm = imm;
        v.fn = fn; v.a = a; v.b = b; v.we = we;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec(OPC_OP,     3'b000, 1'b0, 32'h10,  32'd32,  32'd100, 32'h0,        ALU_ADD,  32'd32,  32'd100,      1'b1);
        add_vec(OPC_OP,     3'b000, 1'b1, 32'h14,  32'd50,  32'd8,   32'h0,        ALU_SUB,  32'd50,  32'd8,        1'b1);
        add_vec(OPC_OP_IMM, 3'b101, 1'b1, 32'h18,  32'd255, 32'd0,   32'h405,      ALU_SRA,  32'd255, 32'h405,      1'b1);
        add_vec(OPC_LUI,    3'b000, 1'b0, 32'h1c,  32'd0,   32'd0,   32'hABCDE000, ALU_PASS, 32'd0,   32'hABCDE000, 1'b1);
        add_vec(OPC_AUIPC,  3'b000, 1'b0, 32'h100, 32'h77,  32'd0,   32'h1000,     ALU_ADD,  32'h100, 32'h1000,     1'b1);
        add_vec(OPC_BRANCH, 3'b000, 1'b0, 32'h20,  32'd5,   32'd6,   32'h10,       ALU_SUB,  32'd5,   32'd6,        1'b0);
        add_vec(OPC_STORE,  3'b010, 1'b0, 32'h24,  32'h200, 32'hdead, 32'd8,       ALU_ADD,  32'h200, 32'd8,        1'b0);
        add_vec(OPC_OP_IMM, 3'b000, 1'b1, 32'h28,  32'd3,   32'd0,   32'h400,      ALU_ADD,  32'd3,   32'h400,      1'b1);
        add_vec(OPC_OP,     3'b111, 1'b0, 32'h2c,  32'hF0,  32'h3C,  32'h0,        ALU_AND,  32'hF0,  32'h3C,       1'b1);
        add_vec(OPC_OP,     3'b101, 1'b0, 32'h30,  32'h80,  32'h3,   32'h0,        ALU_SRL,  32'h80,  32'h3,        1'b1);
        add_vec(OPC_OP_IMM, 3'b010, 1'b0, 32'h34,  32'h9,   32'h0,   32'h7,        ALU_SLT,  32'h9,   32'h7,        1'b1);
        add_vec(OPC_OP,     3'b011, 1'b0, 32'h38,  32'h1,   32'h2,   32'h0,        ALU_SLTU, 32'h1,   32'h2,        1'b1);
        add_vec(OPC_OP,     3'b001, 1'b0, 32'h3c,  32'h1,   32'h1f,  32'h0,        ALU_SLL,  32'h1,   32'h1f,       1'b1);
        add_vec(OPC_OP,     3'b100, 1'b0, 32'h40,  32'hAA,  32'h55,  32'h0,        ALU_XOR,  32'hAA,  32'h55,       1'b1);
        add_vec(OPC_OP,     3'b110, 1'b0, 32'h44,  32'hA0,  32'h0A,  32'h0,        ALU_OR,   32'hA0,  32'h0A,       1'b1);
        add_vec(OPC_JAL,    3'b000, 1'b0, 32'h48,  32'h66,  32'h0,   32'h20,       ALU_ADD,  32'h66,  32'h20,       1'b1);

        #2;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_we", {31'd0, ex_we}, 32'd0);
        chk("reset_alu_fn", {28'd0, alu_fn}, {28'd0, ALU_ADD});
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        chk("reset_ex_pc", ex_pc, 32'd0);
        chk("reset_hazard", {31'd0, hazard_stall}, 32'd0);
        tick();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_id(vecs[i].op, vecs[i].f3, vecs[i].f7, 5'd1, 5'd2, 5'd3,
                   vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].pc);
            tick();
            chk($sformatf("v%0d_alu_fn", i), {28'd0, alu_fn}, {28'd0, vecs[i].fn});
            chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
            chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
            chk($sformatf("v%0d_shamt", i), {27'd0, alu_shamt}, {27'd0, vecs[i].b[4:0]});
            chk($sformatf("v%0d_ex_we", i), {31'd0, ex_we}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_ex_pc", i), ex_pc, vecs[i].pc);
            chk($sformatf("v%0d_store_data", i), ex_store_data, vecs[i].d2);
            chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
        end

        id_valid = 1'b0;
        tick();
        chk("invalid_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("invalid_ex_we", {31'd0, ex_we}, 32'd0);

        // forwarding priority on rs1 and rs2
        set_id(OPC_OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 32'h80);
        tick();
        id_valid = 1'b0;
        exm_rd = 5'd1; exm_we = 1'b1; exm_result = 32'd7;
        wb_rd = 5'd1; wb_we = 1'b1; wb_result = 32'd9;
        #1;
        chk("fwd_exm_over_wb", alu_a, 32'd7);
        chk("fwd_rs2_none", alu_b, 32'h22);
        exm_we = 1'b0;
        #1;
        chk("fwd_wb", alu_a, 32'd9);
        wb_rd = 5'd2;
        #1;
        chk("fwd_rs2_wb", alu_b, 32'd9);
        chk("fwd_rs1_reg", alu_a, 32'h11);
        set_id(OPC_LOAD, 3'b010, 1'b0, 5'd0, 5'd0, 5'd4, 32'h55, 32'h66, 32'h4, 32'h84);
        tick();
        id_valid = 1'b0;
        exm_rd = 5'd0; exm_we = 1'b1; wb_rd = 5'd0; wb_we = 1'b1;
        #1;
        chk("fwd_x0_rs1", alu_a, 32'h55);
        chk("fwd_x0_store", ex_store_data, 32'h66);
        exm_we = 1'b0; wb_we = 1'b0;
        tick();

        // load-use: LW x5 then ADDI x6,x5,1
        set_id(OPC_LOAD, 3'b010, 1'b0, 5'd2, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, 32'h90);
        tick();
        chk("lw_is_load", {31'd0, ex_is_load}, 32'd1);
        set_id(OPC_OP_IMM, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 32'hBAD, 32'h0, 32'h1, 32'h94);
        #1;
        chk("lu_stall", {31'd0, hazard_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall_drop", {31'd0, hazard_stall}, 32'd0);
        wb_rd = 5'd5; wb_we = 1'b1; wb_result = 32'h1234;
        tick();
        chk("lu_addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_addi_pc", ex_pc, 32'h94);
        chk("lu_addi_a_wb", alu_a, 32'h1234);
        chk("lu_addi_b", alu_b, 32'd1);
        chk("lu_no_restall", {31'd0, hazard_stall}, 32'd0);
        wb_we = 1'b0;

        // rs2 use of the load result also stalls
        set_id(OPC_LOAD, 3'b010, 1'b0, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'hA0);
        tick();
        set_id(OPC_STORE, 3'b010, 1'b0, 5'd1, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0, 32'hA4);
        #1;
        chk("lu_rs2_stall", {31'd0, hazard_stall}, 32'd1);
        id_valid = 1'b0;
        #1;
        chk("lu_idle_nostall", {31'd0, hazard_stall}, 32'd0);
        tick();

        // flush together with a stall
        set_id(OPC_LOAD, 3'b010, 1'b0, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'hB0);
        tick();
        set_id(OPC_OP_IMM, 3'b000, 1'b0, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h1, 32'hB4);
        flush = 1'b1;
        #1;
        chk("fl_stall_on", {31'd0, hazard_stall}, 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
        chk("fl_stall_off", {31'd0, hazard_stall}, 32'd0);
        id_valid = 1'b0;
        tick();

        // asynchronous reset while a stall is pending
        set_id(OPC_LOAD, 3'b010, 1'b0, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'hC0);
        tick();
        set_id(OPC_OP, 3'b100, 1'b0, 5'd1, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 32'hC4);
        #1;
        chk("rst_pre_stall", {31'd0, hazard_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_we", {31'd0, ex_we}, 32'd0);
        chk("rst_mid_stall", {31'd0, hazard_stall}, 32'd0);
        chk("rst_mid_fn", {28'd0, alu_fn}, {28'd0, ALU_ADD});
        tick();
        chk("rst_held_valid", {31'd0, ex_valid}, 32'd0);
        rst_n = 1'b1;
        id_valid = 1'b0;
        tick();
        chk("rst_post_bubble", {31'd0, ex_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
